// File: rtl/pe_sequencer_pkg.sv
// Shared types and constants for the PE sequencer and its result FIFO.
package pe_sequencer_pkg;

   // Default depth of the result FIFO
   localparam int FIFO_D_DEF = 2;

   // Width of the step (passes per output minus 1) and bound fields
   localparam int STEP_W  = 3;
   localparam int BOUND_W = 3;

   // Sequencer control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/pe_result_fifo.sv
// Small result FIFO: head is always visible on head/valid, and a push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module pe_result_fifo
   import pe_sequencer_pkg::*;
#(
   parameter int W  = 8,
   parameter int D  = FIFO_D_DEF,
   parameter int CW = $clog2(D + 1)
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic          valid,
   output logic          full,
   output logic [CW-1:0] count
);

   localparam int PW = (D > 1) ? $clog2(D) : 1;

   logic [W-1:0]  mem [0:D-1];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(D - 1)) ? '0 : p + 1'b1;
   endfunction

   assign valid   = (count_reg != '0);
   assign full    = (count_reg == CW'(D));
   assign count   = count_reg;
   assign head    = mem[rd_ptr_reg];
   assign do_pop  = pop && valid;
   assign do_push = push && (!full || do_pop);

   // Storage write; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg] <= push_data;
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push)
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (do_pop)
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         if (do_push && !do_pop)
            count_reg <= count_reg + 1'b1;
         else if (do_pop && !do_push)
            count_reg <= count_reg - 1'b1;
      end
   end

endmodule

// File: rtl/pe_sequencer.sv
// Job sequencer for a processing element: issues groups of step+1 windows,
// tracks results in flight against FIFO credit, and collects PE results.
module pe_sequencer
   import pe_sequencer_pkg::*;
#(
   parameter int OUT_W  = 8,
   parameter int CNT_W  = 16,
   parameter int FIFO_D = FIFO_D_DEF
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [STEP_W-1:0]  cfg_step,
   input  logic [BOUND_W-1:0] cfg_bound,
   input  logic [CNT_W-1:0]   cfg_n_out,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               pe_en,
   output logic [STEP_W-1:0]  pe_step,
   output logic [BOUND_W-1:0] pe_bound,
   input  logic [OUT_W-1:0]   pe_out,
   input  logic               pe_out_en,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [OUT_W-1:0]   res_data,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int FCW = $clog2(FIFO_D + 1);

   state_t             state_reg;
   logic [STEP_W-1:0]  step_reg;
   logic [BOUND_W-1:0] bound_reg;
   logic [CNT_W-1:0]   n_out_reg;
   logic [STEP_W-1:0]  pass_cnt_reg;
   logic [CNT_W-1:0]   issued_reg;
   logic [CNT_W-1:0]   collected_reg;
   logic [FCW-1:0]     gif_reg;
   logic               err_reg;

   logic [FCW-1:0]     fifo_count;
   logic               fifo_full;
   logic [FCW:0]       occupancy;
   logic               group_open;
   logic               can_start;
   logic               group_close;
   logic               res_in;
   logic               res_pop;
   logic               overflow;

   // A group is open once its first window is accepted and until it wraps
   assign group_open  = (pass_cnt_reg != '0);
   assign occupancy   = {1'b0, fifo_count} + {1'b0, gif_reg};
   assign can_start   = (occupancy < (FCW + 1)'(FIFO_D));
   assign in_ready    = (state_reg == ST_RUN) &&
                        (group_open || (can_start && (issued_reg < n_out_reg)));
   assign pe_en       = in_valid && in_ready;
   assign group_close = pe_en && (pass_cnt_reg == step_reg);
   assign res_in      = pe_out_en && (gif_reg != '0);
   assign res_pop     = res_valid && res_ready;
   assign overflow    = res_in && fifo_full && !res_pop;

   assign cfg_ready = (state_reg == ST_IDLE);
   assign busy      = (state_reg != ST_IDLE);
   assign done      = (state_reg == ST_DONE);
   assign err       = err_reg;
   assign pe_step   = step_reg;
   assign pe_bound  = bound_reg;

   pe_result_fifo #(
      .W  (OUT_W),
      .D  (FIFO_D),
      .CW (FCW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (res_in),
      .push_data (pe_out),
      .pop       (res_ready),
      .head      (res_data),
      .valid     (res_valid),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   // Control FSM, group/result counters and sticky error flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         step_reg      <= '0;
         bound_reg     <= '0;
         n_out_reg     <= '0;
         pass_cnt_reg  <= '0;
         issued_reg    <= '0;
         collected_reg <= '0;
         gif_reg       <= '0;
         err_reg       <= 1'b0;
      end else begin
         if (pe_en)
            pass_cnt_reg <= group_close ? '0 : pass_cnt_reg + 1'b1;
         if (group_close)
            issued_reg <= issued_reg + 1'b1;
         if (res_in)
            collected_reg <= collected_reg + 1'b1;
         if (group_close && !res_in)
            gif_reg <= gif_reg + 1'b1;
         else if (res_in && !group_close)
            gif_reg <= gif_reg - 1'b1;

         // Lost accumulation, unexpected result or overflow all flag an error
         if ((state_reg == ST_RUN) && group_open && !in_valid)
            err_reg <= 1'b1;
         if ((pe_out_en && (gif_reg == '0)) || overflow)
            err_reg <= 1'b1;

         case (state_reg)
            ST_IDLE: begin
               if (cfg_valid) begin
                  if (cfg_n_out == '0) begin
                     err_reg <= 1'b1;
                  end else begin
                     step_reg      <= cfg_step;
                     bound_reg     <= cfg_bound;
                     n_out_reg     <= cfg_n_out;
                     pass_cnt_reg  <= '0;
                     issued_reg    <= '0;
                     collected_reg <= '0;
                     gif_reg       <= '0;
                     err_reg       <= 1'b0;
                     state_reg     <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if ((issued_reg == n_out_reg) && !group_open)
                  state_reg <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if ((gif_reg == '0) && (fifo_count == '0) &&
                   (collected_reg == n_out_reg))
                  state_reg <= ST_DONE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer with a 2-cycle-latency PE model.
module tb_pe_sequencer;

   localparam int OUT_W  = 8;
   localparam int CNT_W  = 16;
   localparam int FIFO_D = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [2:0]       cfg_step = '0;
   logic [2:0]       cfg_bound = '0;
   logic [CNT_W-1:0] cfg_n_out = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             pe_en;
   logic [2:0]       pe_step;
   logic [2:0]       pe_bound;
   logic [OUT_W-1:0] pe_out = '0;
   logic             pe_out_en = 1'b0;
   logic             res_valid;
   logic             res_ready = 1'b1;
   logic [OUT_W-1:0] res_data;
   logic             busy;
   logic             done;
   logic             err;

   always #5 clk = ~clk;

   pe_sequencer #(
      .OUT_W  (OUT_W),
      .CNT_W  (CNT_W),
      .FIFO_D (FIFO_D)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_step  (cfg_step),
      .cfg_bound (cfg_bound),
      .cfg_n_out (cfg_n_out),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pe_en     (pe_en),
      .pe_step   (pe_step),
      .pe_bound  (pe_bound),
      .pe_out    (pe_out),
      .pe_out_en (pe_out_en),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // PE model: counts passes against pe_step, emits 0x30+group index
   logic [7:0] pe_grp  = '0;
   logic [2:0] pe_pass = '0;
   logic       d1_v = 1'b0, d2_v = 1'b0;
   logic [7:0] d1 = '0, d2 = '0;

   always @(negedge clk) begin
      if (!reset) begin
         pe_pass   <= '0;
         d1_v      <= 1'b0;
         d2_v      <= 1'b0;
         pe_out_en <= 1'b0;
      end else begin
         d1_v <= 1'b0;
         if (pe_en) begin
            if (pe_pass == pe_step) begin
               d1_v    <= 1'b1;
               d1      <= 8'h30 + pe_grp;
               pe_grp  <= pe_grp + 8'd1;
               pe_pass <= '0;
            end else begin
               pe_pass <= pe_pass + 3'd1;
            end
         end
         d2_v      <= d1_v;
         d2        <= d1;
         pe_out_en <= d2_v;
         pe_out    <= d2;
      end
   end

   // Monitor: results, pe_en activity, done pulses, pe_step stability
   logic [7:0] res_q[$];
   int         pe_en_cnt = 0;
   int         done_cnt  = 0;
   int         step_bad  = 0;
   int         run_bad   = 0;
   int         run_len   = 0;
   logic [2:0] exp_step  = '0;
   logic [7:0] exp_base  = '0;

   always @(negedge clk) begin
      if (reset) begin
         if (res_valid && res_ready) begin
            res_q.push_back(res_data);
            $display("[TB] result %0d = 0x%02h", res_q.size() - 1, res_data);
         end
         if (pe_en) begin
            pe_en_cnt++;
            run_len++;
         end else if (run_len != 0) begin
            if ((run_len % (int'(exp_step) + 1)) != 0)
               run_bad++;
            run_len = 0;
         end
         if (done)
            done_cnt++;
         if (busy && (pe_step != exp_step))
            step_bad++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [2:0] s, input logic [2:0] b, input logic [CNT_W-1:0] n);
      res_q.delete();
      pe_en_cnt = 0;
      done_cnt  = 0;
      step_bad  = 0;
      run_bad   = 0;
      run_len   = 0;
      exp_step  = s;
      exp_base  = pe_grp;
      cfg_step  = s;
      cfg_bound = b;
      cfg_n_out = n;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      $display("[TB] job step=%0d bound=%0d n_out=%0d", s, b, n);
   endtask

   task automatic wait_done(input string tag, input int limit);
      int i = 0;
      while (done_cnt == 0 && i < limit) begin
         tick();
         i++;
      end
      check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
      repeat (3) tick();
      check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic check_results(input string tag, input int n);
      check({tag, "_res_count"}, 32'(res_q.size()), 32'(n));
      for (int i = 0; i < n && i < res_q.size(); i++)
         check($sformatf("%s_res%0d", tag, i), {24'd0, res_q[i]},
               {24'd0, 8'(8'h30 + exp_base + 8'(i))});
   endtask

   initial begin
      repeat (3) tick();
      reset = 1'b1;
      tick();

      // Reset state
      check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      check("rst_in_ready",  {31'd0, in_ready},  32'd0);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
      check("rst_step_bound", {26'd0, pe_step, pe_bound}, 32'd0);

      // S1: step=0, n_out=4
      in_valid  = 1'b1;
      res_ready = 1'b1;
      start_job(3'd0, 3'd3, 16'd4);
      wait_done("s1", 200);
      check("s1_pe_en", 32'(pe_en_cnt), 32'd4);
      check("s1_err", {31'd0, err}, 32'd0);
      check("s1_bound", {29'd0, pe_bound}, 32'd3);
      check_results("s1", 4);

      // S2: step=2, n_out=3
      start_job(3'd2, 3'd5, 16'd3);
      wait_done("s2", 200);
      check("s2_pe_en", 32'(pe_en_cnt), 32'd9);
      check("s2_groups", 32'(run_bad), 32'd0);
      check("s2_step_stable", 32'(step_bad), 32'd0);
      check("s2_pe_step", {29'd0, pe_step}, 32'd2);
      check_results("s2", 3);

      // S3: backpressure on results
      res_ready = 1'b0;
      start_job(3'd0, 3'd0, 16'd5);
      repeat (20) tick();
      check("s3_pe_en_held", 32'(pe_en_cnt), 32'd2);
      check("s3_in_ready", {31'd0, in_ready}, 32'd0);
      check("s3_res_valid", {31'd0, res_valid}, 32'd1);
      check("s3_err_held", {31'd0, err}, 32'd0);
      res_ready = 1'b1;
      wait_done("s3", 300);
      check("s3_err", {31'd0, err}, 32'd0);
      check_results("s3", 5);

      // S4: in_valid drops inside a group
      start_job(3'd1, 3'd0, 16'd2);
      check("s4_first_pe_en", {31'd0, pe_en}, 32'd1);
      tick();
      in_valid = 1'b0;
      tick();
      in_valid = 1'b1;
      check("s4_err_set", {31'd0, err}, 32'd1);
      wait_done("s4", 200);
      check("s4_err_sticky", {31'd0, err}, 32'd1);

      // S5: reset in RUN with one FIFO entry, then a clean job
      res_ready = 1'b0;
      start_job(3'd0, 3'd0, 16'd4);
      check("s5_err_cleared", {31'd0, err}, 32'd0);
      begin
         int i = 0;
         while (!res_valid && i < 20) begin
            tick();
            i++;
         end
      end
      check("s5_entry_seen", {31'd0, res_valid}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check("s5_rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("s5_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      check("s5_rst_busy", {31'd0, busy}, 32'd0);
      tick();
      reset     = 1'b1;
      res_ready = 1'b1;
      tick();
      start_job(3'd0, 3'd1, 16'd3);
      wait_done("s5", 200);
      check("s5_err", {31'd0, err}, 32'd0);
      check("s5_pe_en", 32'(pe_en_cnt), 32'd3);
      check_results("s5", 3);

      // S6: zero-length job is rejected
      start_job(3'd0, 3'd0, 16'd0);
      repeat (5) tick();
      check("s6_err", {31'd0, err}, 32'd1);
      check("s6_busy", {31'd0, busy}, 32'd0);
      check("s6_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      check("s6_pe_en", 32'(pe_en_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 SHALL have parameter OUT_W, default 8, meaning PE result width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning output-count width.
REQ-003 SHALL have parameter FIFO_D, default 2, meaning result FIFO depth.
REQ-004 SHALL have ports, in this order:
- clk  in  1  the only clock
- reset  in  1  asynchronous, active-low
- cfg_valid  in  1  job start request
- cfg_ready  out  1  high only in IDLE
- cfg_step  in  3  passes per output minus 1
- cfg_bound  in  3  bound level
- cfg_n_out  in  CNT_W  outputs in the job; 0 is illegal
- in_valid  in  1  window and weight word available
- in_ready  out  1  window consumed this cycle when in_valid is also high
- pe_en  out  1  PE enable
- pe_step  out  3  to PE
- pe_bound  out  3  to PE
- pe_out  in  OUT_W  PE result
- pe_out_en  in  1  PE result strobe
- res_valid, res_ready  out/in  1  result handshake
- res_data  out  OUT_W  result
- busy  out  1  state is not IDLE
- done  out  1  one-cycle job-complete pulse
- err  out  1  sticky protocol error

Function
REQ-005 SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-006 IDLE: cfg_valid high SHALL latch step, bound and n_out, clear the counters and err, and go to RUN; cfg_valid with cfg_n_out=0 SHALL set err and stay in IDLE.
REQ-007 pe_step and pe_bound SHALL drive the latched values and SHALL hold them stable from RUN through DONE.
REQ-008 A group is step+1 consecutive accepted windows that produce one output.
REQ-009 A group SHALL start only when credit = FIFO_D − (fifo_count + groups_in_flight) is greater than 0.
REQ-010 in_ready SHALL be high in RUN during an open group, or when a group may start and issued < n_out; otherwise in_ready SHALL be low.
REQ-011 pe_en SHALL equal in_valid & in_ready.
REQ-012 pass_cnt SHALL increment on each pe_en and wrap to 0 after step, at which point the group closes, issued increments and groups_in_flight increments.
REQ-013 If in_valid is low during an open group, the PE accumulation is lost; the sequencer SHALL set err and continue counting.
REQ-014 On pe_out_en, pe_out SHALL be pushed into the FIFO and groups_in_flight SHALL decrement; an increment and a decrement in the same cycle SHALL net to zero.
REQ-015 pe_out_en with groups_in_flight=0, or a push into a full FIFO, SHALL set err and drop the data.
REQ-016 The FIFO SHALL present its head on res_data with res_valid; a pop occurs on res_valid & res_ready; a simultaneous push and pop SHALL be allowed when the FIFO is full.
REQ-017 The FIFO SHALL hold res_data stable while res_valid is high and res_ready is low.
REQ-018 RUN SHALL go to DRAIN when issued = n_out and the group is closed.
REQ-019 DRAIN SHALL go to DONE when groups_in_flight = 0, the FIFO is empty and collected = n_out.
REQ-020 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-021 Expected latency: pe_out_en 2 cycles after the last pe_en of a group; the sequencer SHALL tolerate any latency of 1 or more.
REQ-022 err SHALL clear only on reset or on acceptance of a new job.

Reset
REQ-023 Reset low SHALL asynchronously force:
- state to IDLE
- all counters, FIFO pointers, pe_step and pe_bound to 0
- pe_en, in_ready, res_valid, busy, done and err to 0
- cfg_ready to 1 after release
REQ-024 Reset mid-job SHALL abandon the job and discard FIFO contents.

Structure
REQ-025 A shared package SHALL hold the state enum, the FIFO_D default and the step/bound width constants (3).
REQ-026 The result FIFO SHALL be a sub-module named pe_result_fifo; the FSM and counters SHALL stay in pe_sequencer.

Verification
REQ-027 The bench SHALL cover these scenarios:
- step=0, n_out=4, in_valid always 1, res_ready always 1, PE model with 2-cycle latency -> 4 pe_en cycles back-to-back, 4 results in order, one done pulse, err=0.
- step=2, n_out=3 -> pe_en groups of 3 consecutive cycles, pe_step=2 throughout, 3 results.
- step=0, n_out=5, res_ready=0 for 20 cycles -> in_ready low after 2 groups, no overflow, err=0; after release all 5 results and done.
- step=1, in_valid drops for 1 cycle inside a group -> err=1 sticky until the next accepted cfg.
- Reset asserted in RUN with 1 FIFO entry -> res_valid=0 and cfg_ready=1 immediately, and the next job runs correctly.
- cfg_n_out=0 -> err=1, state stays IDLE, no pe_en.
